// File: rtl/uart_hex_sender.sv
// Buffers 32-bit words in a small FIFO and streams each one to the UART as
// 8 uppercase hex characters plus a space or CR LF line terminator.
module uart_hex_sender #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdata_snd_start,
  input  logic [31:0] rdata_snd,
  input  logic        line_reset,
  input  logic        ovf_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flushing_wq,
  output logic        snd_busy,
  output logic        snd_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [PW:0]   PTR_ONE   = (PW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEX, S_SEP, S_CR, S_LF, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   shift_q, shift_d;
  logic [2:0]    nib_q, nib_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;

  logic fifo_empty, fifo_full, pop, push, drop;

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign pop  = (state_q == S_LOAD);
  assign push = rdata_snd_start & (~fifo_full | pop);
  assign drop = rdata_snd_start & fifo_full & ~pop;

  assign snd_busy = ~fifo_empty | (state_q != S_IDLE);
  assign snd_ovf  = ovf_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = rdata_snd;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    nib_d       = nib_q;
    word_cnt_d  = word_cnt_q;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    flushing_wq = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        shift_d = mem_q[rd_ptr_q[PW-1:0]];
        nib_d   = 3'd7;
        state_d = S_HEX;
      end
      S_HEX: begin
        tx_valid = 1'b1;
        tx_data  = to_hex(shift_q[31:28]);
        if (tx_ready) begin
          shift_d = {shift_q[27:0], 4'h0};
          nib_d   = nib_q - 3'd1;
          // Terminator is chosen from the line position at the final nibble.
          if (nib_q == 3'd0) state_d = (word_cnt_q == LAST_WORD) ? S_CR : S_SEP;
        end
      end
      S_SEP: begin
        tx_valid = 1'b1;
        tx_data  = 8'h20;
        if (tx_ready) begin
          state_d    = S_DONE;
          word_cnt_d = word_cnt_q + CNT_ONE;
        end
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_d = S_LF;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) begin
          state_d    = S_DONE;
          word_cnt_d = '0;
        end
      end
      S_DONE: begin
        flushing_wq = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (line_reset) word_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      shift_q    <= '0;
      nib_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      shift_q    <= shift_d;
      nib_q      <= nib_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: stimulus queues expected bytes, a
// negedge monitor pops and compares every accepted byte and flush pulse.
module tb_uart_hex_sender;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdata_snd_start;
  logic [31:0] rdata_snd;
  logic        line_reset;
  logic        ovf_clr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        flushing_wq;
  logic        snd_busy;
  logic        snd_ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int exp_flush = 0;
  int got_flush = 0;
  int exp_cnt = 0;

  logic       prev_sep   = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  uart_hex_sender #(.FIFO_DEPTH(4), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
    .line_reset(line_reset), .ovf_clr(ovf_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .flushing_wq(flushing_wq), .snd_busy(snd_busy), .snd_ovf(snd_ovf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits.getc(int'(n));
  endfunction

  task automatic expect_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ch(w[i*4 +: 4]));
    if (exp_cnt == WPL - 1) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      exp_cnt = 0;
    end else begin
      exp_q.push_back(8'h20);
      exp_cnt++;
    end
    exp_flush++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit accepted);
    rdata_snd_start = 1'b1;
    rdata_snd       = w;
    tick(1);
    rdata_snd_start = 1'b0;
    if (accepted) expect_word(w);
  endtask

  task automatic pulse_line_reset();
    line_reset = 1'b1;
    tick(1);
    line_reset = 1'b0;
    exp_cnt    = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (snd_busy && k < budget) begin
      tick(1);
      k++;
    end
    if (snd_busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: snd_busy still 1 after %0d cycles", budget);
    end
  endtask

  // Monitor: byte order, terminator-to-flush timing and stall stability.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_sep   <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (flushing_wq || prev_sep) check("flush_timing", flushing_wq, prev_sep);
      if (flushing_wq) got_flush++;
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1'b1);
        check("hold_data", tx_data, prev_data);
      end
      prev_sep <= 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL byte: got %h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("byte", tx_data, e);
          prev_sep <= (e == 8'h20) || (e == 8'h0A);
        end
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  initial begin
    int k;
    int base;
    rst_n = 1'b0;
    rdata_snd_start = 1'b0;
    rdata_snd = '0;
    line_reset = 1'b0;
    ovf_clr = 1'b0;
    tx_ready = 1'b1;
    tick(2);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_flush", flushing_wq, 1'b0);
    check("rst_busy", snd_busy, 1'b0);
    check("rst_ovf", snd_ovf, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // Single word with exact latency.
    push_word(32'h12AB_CDEF, 1);
    check("lat_e0_valid", tx_valid, 1'b0);
    check("lat_e0_busy", snd_busy, 1'b1);
    tick(1);
    check("lat_load_valid", tx_valid, 1'b0);
    tick(1);
    check("lat_first_valid", tx_valid, 1'b1);
    check("lat_first_data", tx_data, 8'h31);
    tick(9);
    check("lat_flush", flushing_wq, 1'b1);
    tick(1);
    check("lat_flush_end", flushing_wq, 1'b0);
    check("lat_idle", snd_busy, 1'b0);

    // Four back-to-back words; the fourth closes the line.
    pulse_line_reset();
    base = got_flush;
    for (int i = 0; i < 4; i++) push_word(i, 1);
    wait_idle(100);
    check("b2b_flushes", got_flush - base, 4);

    // Throttled handshake: ready 1 cycle in 4.
    tx_ready = 1'b0;
    push_word(32'hFFFF_FFFF, 1);
    k = 0;
    while ((snd_busy || k < 4) && k < 200) begin
      tx_ready = (k % 4 == 0);
      tick(1);
      k++;
    end
    tx_ready = 1'b1;
    check("throttle_done", snd_busy, 1'b0);

    // Overflow: one word in the shift register, four in the FIFO, sixth dropped.
    tx_ready = 1'b0;
    push_word(32'hA000_0001, 1);
    tick(3);
    for (int i = 2; i <= 5; i++) push_word(32'hA000_0000 + i, 1);
    check("ovf_before", snd_ovf, 1'b0);
    push_word(32'hA000_0006, 0);
    check("ovf_set", snd_ovf, 1'b1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", snd_ovf, 1'b0);
    ovf_clr = 1'b1;
    push_word(32'hA000_0007, 0);
    ovf_clr = 1'b0;
    check("ovf_set_wins", snd_ovf, 1'b1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr2", snd_ovf, 1'b0);
    tx_ready = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!flushing_wq && k < 100);
    check("ovf_first_flush", flushing_wq, 1'b1);
    tick(2);
    // Now in LOAD with a full FIFO: this push coincides with the pop.
    push_word(32'hA000_0008, 1);
    check("push_with_pop_no_ovf", snd_ovf, 1'b0);
    wait_idle(200);

    // line_reset moves the CR LF to the fourth word after it.
    pulse_line_reset();
    push_word(32'hB000_0001, 1);
    push_word(32'hB000_0002, 1);
    wait_idle(100);
    pulse_line_reset();
    for (int i = 3; i <= 6; i++) push_word(32'hB000_0000 + i, 1);
    wait_idle(200);

    // Reset after three hex bytes aborts the word silently.
    push_word(32'hC0FF_EE11, 1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("abort_valid", tx_valid, 1'b0);
    check("abort_busy", snd_busy, 1'b0);
    check("abort_flush", flushing_wq, 1'b0);
    exp_q.delete();
    exp_flush--;
    exp_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push_word(32'h0DEC_AF05, 1);
    wait_idle(100);
    tick(2);

    check("exp_q_empty", exp_q.size(), 0);
    check("flush_total", got_flush, exp_flush);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
